// File: rtl/dispatch_unit_pkg.sv
// Shared definitions for the dispatch stage: internal opcodes, MIPS encodings
// and the issue-class enum used to route instructions.
package dispatch_unit_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int TAG_W_DEF    = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_ADDI = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;

    localparam logic [5:0] MIPS_RTYPE = 6'h00;
    localparam logic [5:0] MIPS_J     = 6'h02;
    localparam logic [5:0] MIPS_BEQ   = 6'h04;
    localparam logic [5:0] MIPS_ADDI  = 6'h08;
    localparam logic [5:0] MIPS_LW    = 6'h23;
    localparam logic [5:0] MIPS_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        CLASS_INT,
        CLASS_LDST,
        CLASS_MUL,
        CLASS_JMP,
        CLASS_NOP
    } instr_class_e;

endpackage

// File: rtl/dispatch_unit_rst.sv
// Register file and register status table with two combinational source read
// ports and one rename write port that marks a destination pending.
module dispatch_unit_rst
    import dispatch_unit_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rs_addr,
    input  logic [AW-1:0]    rt_addr,
    output logic [31:0]      rs_data,
    output logic             rs_valid,
    output logic [TAG_W-1:0] rs_tag,
    output logic [31:0]      rt_data,
    output logic             rt_valid,
    output logic [TAG_W-1:0] rt_tag,
    input  logic             rename_we,
    input  logic [AW-1:0]    rename_addr,
    input  logic [TAG_W-1:0] rename_tag
);

    logic [NUM_REGS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q     [NUM_REGS];
    logic [TAG_W-1:0]    tag_d     [NUM_REGS];
    logic [31:0]         regfile_q [NUM_REGS];
    logic [31:0]         regfile_d [NUM_REGS];

    // No result bus feeds this table, so the register file only holds its reset image.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        regfile_d = regfile_q;
        if (rename_we && (rename_addr != '0)) begin
            valid_d[rename_addr] = 1'b0;
            tag_d[rename_addr]   = rename_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '1;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_q[i]     <= '0;
                regfile_q[i] <= 32'(i);
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            regfile_q <= regfile_d;
        end
    end

    // Reads see the pre-update state, so a source equal to its own dest reads the old status.
    always_comb begin
        rs_valid = valid_q[rs_addr];
        rs_tag   = tag_q[rs_addr];
        rs_data  = valid_q[rs_addr] ? regfile_q[rs_addr] : '0;
        if (rs_addr == '0) begin
            rs_valid = 1'b1;
            rs_data  = '0;
        end
        rt_valid = valid_q[rt_addr];
        rt_tag   = tag_q[rt_addr];
        rt_data  = valid_q[rt_addr] ? regfile_q[rt_addr] : '0;
        if (rt_addr == '0) begin
            rt_valid = 1'b1;
            rt_data  = '0;
        end
    end

endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatch stage: decodes the fetch-queue head, reads operand status,
// allocates a destination tag and routes to the integer/ld-st/mul queues.
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ifetch_pc_4,
    input  logic [31:0]      ifetch_intruction,
    input  logic             ifetch_empty,
    output logic [31:0]      Dispatch_jmp_addr,
    output logic             Dispatch_jmp,
    output logic             Dispatch_ren,
    output logic [31:0]      dispatch_rs_data,
    output logic             dispatch_rs_data_valid,
    output logic [TAG_W-1:0] dispatch_rs_tag,
    output logic [31:0]      dispatch_rt_data,
    output logic             dispatch_rt_data_valid,
    output logic [TAG_W-1:0] dispatch_rt_tag,
    output logic [TAG_W-1:0] dispatch_rd_tag,
    output logic             dispatch_en_integer,
    input  logic             issueque_integer_full,
    output logic [3:0]       dispatch_opcode,
    output logic [4:0]       dispatch_shfamt,
    output logic             dispatch_en_ld_st,
    input  logic             issueque_full_ld_st,
    output logic [15:0]      dispatch_imm_ld_st,
    output logic             dispatch_en_mul,
    input  logic             issueque_mul_full
);

    localparam int AW = $clog2(NUM_REGS);

    logic [5:0]       mips_op, mips_funct;
    instr_class_e     iclass;
    logic             has_dest;
    logic [AW-1:0]    dest;
    logic             queue_full;
    logic             rename_we;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [27:0]      pc_low_unused;

    assign mips_op       = ifetch_intruction[31:26];
    assign mips_funct    = ifetch_intruction[5:0];
    assign pc_low_unused = ifetch_pc_4[27:0];

    always_comb begin
        iclass          = CLASS_NOP;
        dispatch_opcode = OP_ADD;
        has_dest        = 1'b0;
        dest            = AW'(ifetch_intruction[15:11]);
        case (mips_op)
            MIPS_RTYPE: begin
                has_dest = 1'b1;
                iclass   = CLASS_INT;
                case (mips_funct)
                    FUNCT_ADD:   dispatch_opcode = OP_ADD;
                    FUNCT_SUB:   dispatch_opcode = OP_SUB;
                    FUNCT_AND:   dispatch_opcode = OP_AND;
                    FUNCT_OR:    dispatch_opcode = OP_OR;
                    FUNCT_SLT:   dispatch_opcode = OP_SLT;
                    FUNCT_SLL:   dispatch_opcode = OP_SLL;
                    FUNCT_SRL:   dispatch_opcode = OP_SRL;
                    FUNCT_MULT, FUNCT_MULTU: begin
                        iclass          = CLASS_MUL;
                        dispatch_opcode = OP_MUL;
                    end
                    default: begin
                        iclass   = CLASS_NOP;
                        has_dest = 1'b0;
                    end
                endcase
            end
            MIPS_LW: begin
                iclass          = CLASS_LDST;
                dispatch_opcode = OP_LW;
                has_dest        = 1'b1;
                dest            = AW'(ifetch_intruction[20:16]);
            end
            MIPS_SW: begin
                iclass          = CLASS_LDST;
                dispatch_opcode = OP_SW;
            end
            MIPS_ADDI: begin
                iclass          = CLASS_INT;
                dispatch_opcode = OP_ADDI;
                has_dest        = 1'b1;
                dest            = AW'(ifetch_intruction[20:16]);
            end
            MIPS_BEQ: begin
                iclass          = CLASS_INT;
                dispatch_opcode = OP_BEQ;
            end
            MIPS_J:  iclass = CLASS_JMP;
            default: iclass = CLASS_NOP;
        endcase
    end

    // Jumps and nops never wait on a queue, so only the routed class can stall.
    always_comb begin
        queue_full = 1'b0;
        case (iclass)
            CLASS_INT:  queue_full = issueque_integer_full;
            CLASS_LDST: queue_full = issueque_full_ld_st;
            CLASS_MUL:  queue_full = issueque_mul_full;
            default:    queue_full = 1'b0;
        endcase
        Dispatch_ren        = !reset && !ifetch_empty && !queue_full;
        dispatch_en_integer = Dispatch_ren && (iclass == CLASS_INT);
        dispatch_en_ld_st   = Dispatch_ren && (iclass == CLASS_LDST);
        dispatch_en_mul     = Dispatch_ren && (iclass == CLASS_MUL);
        Dispatch_jmp        = Dispatch_ren && (iclass == CLASS_JMP);
        rename_we           = Dispatch_ren && has_dest && (dest != '0);
        tag_cnt_d           = rename_we ? tag_cnt_q + 1'b1 : tag_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_cnt_q <= '0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
        end
    end

    assign Dispatch_jmp_addr  = {ifetch_pc_4[31:28], ifetch_intruction[25:0], 2'b00};
    assign dispatch_rd_tag    = tag_cnt_q;
    assign dispatch_shfamt    = ifetch_intruction[10:6];
    assign dispatch_imm_ld_st = ifetch_intruction[15:0];

    dispatch_unit_rst #(
        .NUM_REGS (NUM_REGS),
        .TAG_W    (TAG_W)
    ) u_rst (
        .clock       (clock),
        .reset       (reset),
        .rs_addr     (AW'(ifetch_intruction[25:21])),
        .rt_addr     (AW'(ifetch_intruction[20:16])),
        .rs_data     (dispatch_rs_data),
        .rs_valid    (dispatch_rs_data_valid),
        .rs_tag      (dispatch_rs_tag),
        .rt_data     (dispatch_rt_data),
        .rt_valid    (dispatch_rt_data_valid),
        .rt_tag      (dispatch_rt_tag),
        .rename_we   (rename_we),
        .rename_addr (dest),
        .rename_tag  (tag_cnt_q)
    );

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: a stateful vector table whose expected
// outputs are queued at drive time and popped when the outputs are sampled.
module tb_dispatch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] ifetch_pc_4;
    logic [31:0] ifetch_intruction;
    logic        ifetch_empty;
    logic [31:0] Dispatch_jmp_addr;
    logic        Dispatch_jmp;
    logic        Dispatch_ren;
    logic [31:0] dispatch_rs_data;
    logic        dispatch_rs_data_valid;
    logic [4:0]  dispatch_rs_tag;
    logic [31:0] dispatch_rt_data;
    logic        dispatch_rt_data_valid;
    logic [4:0]  dispatch_rt_tag;
    logic [4:0]  dispatch_rd_tag;
    logic        dispatch_en_integer;
    logic        issueque_integer_full;
    logic [3:0]  dispatch_opcode;
    logic [4:0]  dispatch_shfamt;
    logic        dispatch_en_ld_st;
    logic        issueque_full_ld_st;
    logic [15:0] dispatch_imm_ld_st;
    logic        dispatch_en_mul;
    logic        issueque_mul_full;

    dispatch_unit dut (
        .clock                  (clock),
        .reset                  (reset),
        .ifetch_pc_4            (ifetch_pc_4),
        .ifetch_intruction      (ifetch_intruction),
        .ifetch_empty           (ifetch_empty),
        .Dispatch_jmp_addr      (Dispatch_jmp_addr),
        .Dispatch_jmp           (Dispatch_jmp),
        .Dispatch_ren           (Dispatch_ren),
        .dispatch_rs_data       (dispatch_rs_data),
        .dispatch_rs_data_valid (dispatch_rs_data_valid),
        .dispatch_rs_tag        (dispatch_rs_tag),
        .dispatch_rt_data       (dispatch_rt_data),
        .dispatch_rt_data_valid (dispatch_rt_data_valid),
        .dispatch_rt_tag        (dispatch_rt_tag),
        .dispatch_rd_tag        (dispatch_rd_tag),
        .dispatch_en_integer    (dispatch_en_integer),
        .issueque_integer_full  (issueque_integer_full),
        .dispatch_opcode        (dispatch_opcode),
        .dispatch_shfamt        (dispatch_shfamt),
        .dispatch_en_ld_st      (dispatch_en_ld_st),
        .issueque_full_ld_st    (issueque_full_ld_st),
        .dispatch_imm_ld_st     (dispatch_imm_ld_st),
        .dispatch_en_mul        (dispatch_en_mul),
        .issueque_mul_full      (issueque_mul_full)
    );

    typedef struct {
        logic        rst, empty, int_full, ldst_full, mul_full;
        logic [31:0] pc4, instr;
        logic        ren, jmp, e_int, e_ldst, e_mul;
        logic [3:0]  opc;
        logic [31:0] rs_d;
        logic        rs_v;
        logic [4:0]  rs_t;
        logic [31:0] rt_d;
        logic        rt_v;
        logic [4:0]  rt_t;
        logic [4:0]  rd_t;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cur_vec = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic rst, empty, int_full, ldst_full, mul_full,
        input logic [31:0] pc4, instr,
        input logic ren, jmp, e_int, e_ldst, e_mul,
        input logic [3:0] opc,
        input logic [31:0] rs_d, input logic rs_v, input logic [4:0] rs_t,
        input logic [31:0] rt_d, input logic rt_v, input logic [4:0] rt_t,
        input logic [4:0] rd_t);
        vec_t v;
        v.rst = rst; v.empty = empty; v.int_full = int_full;
        v.ldst_full = ldst_full; v.mul_full = mul_full;
        v.pc4 = pc4; v.instr = instr;
        v.ren = ren; v.jmp = jmp; v.e_int = e_int; v.e_ldst = e_ldst; v.e_mul = e_mul;
        v.opc = opc;
        v.rs_d = rs_d; v.rs_v = rs_v; v.rs_t = rs_t;
        v.rt_d = rt_d; v.rt_v = rt_v; v.rt_t = rt_t;
        v.rd_t = rd_t;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, cur_vec, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clock);
        #1;
        reset                 = v.rst;
        ifetch_empty          = v.empty;
        issueque_integer_full = v.int_full;
        issueque_full_ld_st   = v.ldst_full;
        issueque_mul_full     = v.mul_full;
        ifetch_pc_4           = v.pc4;
        ifetch_intruction     = v.instr;
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        logic [31:0] exp_addr;
        #3;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard (vector %0d): got empty queue, expected an entry", cur_vec);
            return;
        end
        e = sb.pop_front();
        exp_addr = {e.pc4[31:28], e.instr[25:0], 2'b00};
        checkField("ren",      32'(Dispatch_ren),           32'(e.ren));
        checkField("jmp",      32'(Dispatch_jmp),           32'(e.jmp));
        checkField("jmp_addr", Dispatch_jmp_addr,           exp_addr);
        checkField("en_int",   32'(dispatch_en_integer),    32'(e.e_int));
        checkField("en_ldst",  32'(dispatch_en_ld_st),      32'(e.e_ldst));
        checkField("en_mul",   32'(dispatch_en_mul),        32'(e.e_mul));
        if (e.e_int || e.e_ldst || e.e_mul)
            checkField("opcode", 32'(dispatch_opcode), 32'(e.opc));
        checkField("shfamt",   32'(dispatch_shfamt),        32'(e.instr[10:6]));
        checkField("imm",      32'(dispatch_imm_ld_st),     32'(e.instr[15:0]));
        checkField("rs_data",  dispatch_rs_data,            e.rs_d);
        checkField("rs_valid", 32'(dispatch_rs_data_valid), 32'(e.rs_v));
        checkField("rs_tag",   32'(dispatch_rs_tag),        32'(e.rs_t));
        checkField("rt_data",  dispatch_rt_data,            e.rt_d);
        checkField("rt_valid", 32'(dispatch_rt_data_valid), 32'(e.rt_v));
        checkField("rt_tag",   32'(dispatch_rt_tag),        32'(e.rt_t));
        checkField("rd_tag",   32'(dispatch_rd_tag),        32'(e.rd_t));
    endtask

    localparam logic [31:0] I_ADD31  = 32'h0080F820;
    localparam logic [31:0] I_MUL2   = 32'h00BF1018;
    localparam logic [31:0] I_NOPADD = 32'h00000020;
    localparam logic [31:0] I_JMP    = 32'h08000010;
    localparam logic [31:0] I_LW3    = 32'h8C430008;
    localparam logic [31:0] I_SW     = 32'hAFE30004;
    localparam logic [31:0] I_ADDI7  = 32'h20870005;
    localparam logic [31:0] I_BEQ    = 32'h10E40003;
    localparam logic [31:0] I_SLL5   = 32'h000428C0;
    localparam logic [31:0] I_BADOP  = 32'hFC000000;
    localparam logic [31:0] I_BADFN  = 32'h00A0003F;
    localparam logic [31:0] I_SUB0   = 32'h00220022;
    localparam logic [31:0] I_SLT0   = 32'h0023002A;
    localparam logic [31:0] I_MULTU0 = 32'h00C70019;
    localparam logic [31:0] PC       = 32'h00001004;

    initial begin
        reset = 1'b1; ifetch_empty = 1'b0; ifetch_pc_4 = PC; ifetch_intruction = I_ADD31;
        issueque_integer_full = 1'b0; issueque_full_ld_st = 1'b0; issueque_mul_full = 1'b0;

        //            rst e  if lf mf pc4          instr     ren j  ei el em opc  rs_d v  t  rt_d v  t  rd
        vecs.push_back(mk(1, 0, 0, 0, 0, PC,          I_ADD31,  0, 0, 0, 0, 0, 0,  4,  1, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_ADD31,  1, 0, 1, 0, 0, 0,  4,  1, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_ADD31,  1, 0, 1, 0, 0, 0,  4,  1, 0, 0,  1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_ADD31,  1, 0, 1, 0, 0, 0,  4,  1, 0, 0,  1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_ADD31,  1, 0, 1, 0, 0, 0,  4,  1, 0, 0,  1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_MUL2,   1, 0, 0, 0, 1, 7,  5,  1, 0, 0,  0, 3, 4));
        vecs.push_back(mk(0, 0, 0, 0, 1, PC,          I_MUL2,   0, 0, 0, 0, 0, 7,  5,  1, 0, 0,  0, 3, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_MUL2,   1, 0, 0, 0, 1, 7,  5,  1, 0, 0,  0, 3, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_NOPADD, 1, 0, 1, 0, 0, 0,  0,  1, 0, 0,  1, 0, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_NOPADD, 1, 0, 1, 0, 0, 0,  0,  1, 0, 0,  1, 0, 6));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h40000004, I_JMP,   1, 1, 0, 0, 0, 0,  0,  1, 0, 0,  1, 0, 6));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h40000004, I_JMP,   0, 0, 0, 0, 0, 0,  0,  1, 0, 0,  1, 0, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_LW3,    1, 0, 0, 1, 0, 8,  0,  0, 5, 3,  1, 0, 6));
        vecs.push_back(mk(0, 0, 0, 1, 0, PC,          I_LW3,    0, 0, 0, 0, 0, 8,  0,  0, 5, 0,  0, 6, 7));
        vecs.push_back(mk(0, 0, 1, 0, 1, PC,          I_SW,     1, 0, 0, 1, 0, 9,  0,  0, 3, 0,  0, 6, 7));
        vecs.push_back(mk(0, 0, 1, 0, 0, PC,          I_ADDI7,  0, 0, 0, 0, 0, 10, 4,  1, 0, 7,  1, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_ADDI7,  1, 0, 1, 0, 0, 10, 4,  1, 0, 7,  1, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_BEQ,    1, 0, 1, 0, 0, 11, 0,  0, 7, 4,  1, 0, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_SLL5,   1, 0, 1, 0, 0, 5,  0,  1, 0, 4,  1, 0, 8));
        vecs.push_back(mk(0, 0, 1, 1, 1, PC,          I_BADOP,  1, 0, 0, 0, 0, 0,  0,  1, 0, 0,  1, 0, 9));
        vecs.push_back(mk(0, 0, 1, 1, 1, PC,          I_BADFN,  1, 0, 0, 0, 0, 0,  0,  0, 8, 0,  1, 0, 9));
        // Mid-stream reset: outputs still show the pending state, next cycle everything is clean.
        vecs.push_back(mk(1, 0, 0, 0, 0, PC,          I_MUL2,   0, 0, 0, 0, 0, 7,  0,  0, 8, 0,  0, 3, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_MUL2,   1, 0, 0, 0, 1, 7,  5,  1, 0, 31, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_SUB0,   1, 0, 1, 0, 0, 1,  1,  1, 0, 0,  0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_SLT0,   1, 0, 1, 0, 0, 4,  1,  1, 0, 3,  1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, PC,          I_MULTU0, 1, 0, 0, 0, 1, 7,  6,  1, 0, 7,  1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            cur_vec = i;
            applyStimulus(vecs[i]);
            checkOutput();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
In-order dispatch stage of the Tomasulo-style MIPS core, between the instruction fetch queue and the three issue queues (integer, load/store, multiply). Each cycle it decodes the instruction at the head of the fetch queue and reads source operands from an internal register file and register status table (RST). It allocates a destination tag, routes the instruction to the matching issue queue, and resolves unconditional jumps.

Parameters:
NUM_REGS, 32, architectural registers (RST and register file depth)
TAG_W, 5, tag width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
ifetch_pc_4  in  32  PC+4 of the head instruction
ifetch_intruction  in  32  head instruction word
ifetch_empty  in  1  fetch queue empty
Dispatch_jmp_addr  out  32  jump target
Dispatch_jmp  out  1  redirect fetch to Dispatch_jmp_addr
Dispatch_ren  out  1  pop the fetch queue (instruction consumed)
dispatch_rs_data  out  32  rs value (0 when not valid)
dispatch_rs_data_valid  out  1  rs value ready
dispatch_rs_tag  out  5  producer tag of rs when not ready
dispatch_rt_data  out  32  rt value (0 when not valid)
dispatch_rt_data_valid  out  1  rt value ready
dispatch_rt_tag  out  5  producer tag of rt
dispatch_rd_tag  out  5  tag allocated to the destination
dispatch_en_integer  out  1  write integer issue queue
issueque_integer_full  in  1  integer queue full
dispatch_opcode  out  4  internal opcode
dispatch_shfamt  out  5  instr[10:6]
dispatch_en_ld_st  out  1  write load/store queue
issueque_full_ld_st  in  1  load/store queue full
dispatch_imm_ld_st  out  16  instr[15:0]
dispatch_en_mul  out  1  write multiply queue
issueque_mul_full  in  1  multiply queue full

Behaviour:
- One clock; reset is synchronous and active-high. All decode and operand outputs are combinational from the instruction and current state. State updates on the rising clock edge.
- Reset values:
  - Tag counter = 0.
  - All RST entries valid, tag 0.
  - Register file entry i = i (so $4 = 4).
  - While reset is high, Dispatch_ren, Dispatch_jmp and all en_* outputs are 0.
- Decode, in the form class / internal opcode:
  - R-type (op 0) with funct add 0x20 / sub 0x22 / and 0x24 / or 0x25 / slt 0x2A / sll 0x00 / srl 0x02 → integer class, opcodes 0..6.
  - funct 0x18 or 0x19 → mul class, opcode 7.
  - lw (0x23) → ld_st class, opcode 8, dest rt.
  - sw (0x2B) → ld_st class, opcode 9, no dest.
  - addi (0x08) → integer class, opcode 10, dest rt.
  - beq (0x04) → integer class, opcode 11, no dest.
  - j (0x02) → jump class.
  - Anything else → nop class.
  - R-type destination is rd = instr[15:11].
- Dispatch_ren = !reset & !ifetch_empty & !(target queue full). Jump and nop classes are never blocked.
- Enables: en_integer, en_ld_st and en_mul each = Dispatch_ren & (class matches). At most one enable is high at a time.
- Jump: Dispatch_jmp = Dispatch_ren & jump class. Dispatch_jmp_addr = {ifetch_pc_4[31:28], instr[25:0], 2'b00}. Dispatch_jmp_addr is driven for every instruction and qualified by Dispatch_jmp.
- Operands: rs = instr[25:21], rt = instr[20:16].
  - data_valid = RST valid bit.
  - tag = RST tag.
  - data = register file value when valid, else 0.
  - Register $0 always reads valid, data 0.
  - Sources are read before the same-cycle destination update, so an instruction whose source equals its own dest sees the old status.
- dispatch_rd_tag = tag counter.
- On a dispatch with a destination other than $0:
  - RST[dest] becomes {valid=0, tag=counter}.
  - Counter increments, wrapping 31→0.
- Dispatches with no destination, or with dest $0, do not consume a tag.
- The block has no result-bus input: pending registers stay pending until reset, and the register file is never written after reset.
- A stable, non-empty head instruction with a non-full queue dispatches every cycle. Each such dispatch is a new instruction instance.

Decomposition:
- Shared package: internal opcode constants (0..11), MIPS opcode/funct constants, class enum {INT, LDST, MUL, JMP, NOP}.
- One sub-module, dispatch_rst: register file plus RST with two combinational read ports and one rename write port.
- Decode and the tag counter live in the top.

Test Plan:
- Reset, then instr 0x0080F820 (add $31,$4,$0), queues not full → ren=1, en_integer=1, opcode=0, rs_data=4 valid, rt_data=0 valid, rd_tag=0. After 4 cycles held: tag counter=4, RST[$31]={0, tag 3}.
- Then 0x00BF1018 (mul $2,$5,$31) → en_mul=1, opcode=7, rs_data=5 valid, rt_data_valid=0, rt_tag=3, rd_tag=4.
- mul with issueque_mul_full=1 → ren=0, en_mul=0, counter unchanged. Deassert full → dispatches the next cycle.
- 0x00000020 (nop add $0) → en_integer=1, rd_tag=current counter, counter not incremented.
- pc_4=0x40000004, instr 0x08000010 → Dispatch_jmp=1, addr=0x40000040, ren=1, no enables.
- ifetch_empty=1 → ren, jmp and all enables 0; assert reset mid-stream → next cycle counter=0 and all registers valid.
